// File: rtl/bus_cmd_initiator_if.sv
// rtl/bus_cmd_initiator_if.sv - command byte stream, memory bus and read-result handshake bundle
interface bus_cmd_initiator_if;
  logic [7:0]  cmd_data_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [16:0] bus_addr_o;
  logic [7:0]  bus_wr_data_o;
  logic        bus_we_o;
  logic        bus_req_o;
  logic        bus_grant_i;
  logic [7:0]  bus_rd_data_i;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic        err_o;

  modport master (
    input  cmd_data_i, cmd_valid_i, bus_grant_i, bus_rd_data_i, rd_ready_i,
    output cmd_ready_o, bus_addr_o, bus_wr_data_o, bus_we_o, bus_req_o,
           rd_data_o, rd_valid_o, err_o
  );

  modport slave (
    output cmd_data_i, cmd_valid_i, bus_grant_i, bus_rd_data_i, rd_ready_i,
    input  cmd_ready_o, bus_addr_o, bus_wr_data_o, bus_we_o, bus_req_o,
           rd_data_o, rd_valid_o, err_o
  );
endinterface

// File: rtl/bus_cmd_initiator.sv
// rtl/bus_cmd_initiator.sv - byte-command decoder issuing single read/write accesses on a 17-bit bus
module bus_cmd_initiator (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bus_cmd_initiator_if.master  bus
);
  typedef enum logic [2:0] {IDLE, ARG_DATA, ARG_HI, ARG_LO, ACCESS, RESULT} state_t;

  state_t      state_q, state_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        we_q, we_d;
  logic        at_q, at_d;
  logic        err_q, err_d;
  logic        accept;
  logic [2:0]  op;

  assign op     = bus.cmd_data_i[7:5];
  assign accept = bus.cmd_valid_i && bus.cmd_ready_o;

  assign bus.cmd_ready_o   = (state_q == IDLE) || (state_q == ARG_DATA) ||
                             (state_q == ARG_HI) || (state_q == ARG_LO);
  assign bus.bus_req_o     = (state_q == ACCESS);
  assign bus.bus_addr_o    = addr_q;
  assign bus.bus_we_o      = we_q;
  assign bus.bus_wr_data_o = wr_data_q;
  assign bus.rd_data_o     = rd_data_q;
  assign bus.rd_valid_o    = (state_q == RESULT);
  assign bus.err_o         = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      we_q      <= 1'b0;
      at_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      we_q      <= we_d;
      at_q      <= at_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    we_d      = we_q;
    at_d      = at_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            3'b000: begin
              we_d       = 1'b0;
              at_d       = 1'b1;
              addr_d[16] = bus.cmd_data_i[0];
              state_d    = ARG_HI;
            end
            3'b001: begin
              we_d       = 1'b1;
              at_d       = 1'b1;
              addr_d[16] = bus.cmd_data_i[0];
              state_d    = ARG_DATA;
            end
            3'b010: begin
              we_d    = 1'b0;
              at_d    = 1'b0;
              addr_d  = addr_q + 17'd1;
              state_d = ACCESS;
            end
            3'b011: begin
              we_d    = 1'b1;
              at_d    = 1'b0;
              state_d = ARG_DATA;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ARG_DATA: begin
        if (accept) begin
          wr_data_d = bus.cmd_data_i;
          if (at_q) begin
            state_d = ARG_HI;
          end else begin
            // WRITE_NEXT: the data byte is the final byte, so pre-increment here
            addr_d  = addr_q + 17'd1;
            state_d = ACCESS;
          end
        end
      end
      ARG_HI: begin
        if (accept) begin
          addr_d[15:8] = bus.cmd_data_i;
          state_d      = ARG_LO;
        end
      end
      ARG_LO: begin
        if (accept) begin
          addr_d[7:0] = bus.cmd_data_i;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.bus_grant_i) begin
          if (we_q) begin
            state_d = IDLE;
          end else begin
            rd_data_d = bus.bus_rd_data_i;
            state_d   = RESULT;
          end
        end
      end
      RESULT: begin
        if (bus.rd_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_cmd_initiator.sv
// tb/tb_bus_cmd_initiator.sv - directed and randomized self-checking bench for bus_cmd_initiator
module tb_bus_cmd_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_cmd_initiator_if bus_if ();

  bus_cmd_initiator dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus_if.cmd_valid_i = 1'b0;
    repeat (gap) tick();
    bus_if.cmd_data_i  = b;
    bus_if.cmd_valid_i = 1'b1;
    while (bus_if.cmd_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL cmd_accept_timeout byte=%h ready=%b required=1", b, bus_if.cmd_ready_o);
    end else begin
      tick();
    end
    bus_if.cmd_valid_i = 1'b0;
  endtask

  task automatic grant(input logic [7:0] rd);
    bus_if.bus_grant_i   = 1'b1;
    bus_if.bus_rd_data_i = rd;
    tick();
    bus_if.bus_grant_i   = 1'b0;
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    bus_if.cmd_valid_i  = 1'b0;
    bus_if.bus_grant_i  = 1'b0;
    bus_if.rd_ready_i   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_if.cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", bus_if.cmd_ready_o); end
    checks++; if (bus_if.bus_req_o !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%b exp=0", bus_if.bus_req_o); end
    checks++; if (bus_if.bus_we_o !== 1'b0) begin failures++; $display("FAIL reset_bus_we got=%b exp=0", bus_if.bus_we_o); end
    checks++; if (bus_if.bus_wr_data_o !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", bus_if.bus_wr_data_o); end
    checks++; if (bus_if.bus_addr_o !== 17'h00000) begin failures++; $display("FAIL reset_addr got=%h exp=00000", bus_if.bus_addr_o); end
    checks++; if (bus_if.rd_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus_if.rd_valid_o); end
    checks++; if (bus_if.rd_data_o !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", bus_if.rd_data_o); end
    checks++; if (bus_if.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_if.err_o); end
  endtask

  task automatic test_write_at();
    send_byte(8'h21, 0);
    send_byte(8'h5A, 0);
    send_byte(8'h80, 1);
    send_byte(8'h00, 0);
    checks++; if (bus_if.bus_req_o !== 1'b1) begin failures++; $display("FAIL wr_at_req got=%b exp=1", bus_if.bus_req_o); end
    checks++; if (bus_if.cmd_ready_o !== 1'b0) begin failures++; $display("FAIL wr_at_ready got=%b exp=0", bus_if.cmd_ready_o); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus_if.bus_req_o !== 1'b1 || bus_if.bus_addr_o !== 17'h18000 ||
          bus_if.bus_we_o !== 1'b1 || bus_if.bus_wr_data_o !== 8'h5A) begin
        failures++;
        $display("FAIL wr_at_hold req=%b addr=%h we=%b data=%h exp 1/18000/1/5a",
                 bus_if.bus_req_o, bus_if.bus_addr_o, bus_if.bus_we_o, bus_if.bus_wr_data_o);
      end
      tick();
    end
    grant(8'hEE);
    checks++; if (bus_if.bus_req_o !== 1'b0) begin failures++; $display("FAIL wr_at_done_req got=%b exp=0", bus_if.bus_req_o); end
    checks++; if (bus_if.cmd_ready_o !== 1'b1) begin failures++; $display("FAIL wr_at_done_ready got=%b exp=1", bus_if.cmd_ready_o); end
    checks++; if (bus_if.rd_valid_o !== 1'b0) begin failures++; $display("FAIL wr_at_rd_valid got=%b exp=0", bus_if.rd_valid_o); end
  endtask

  task automatic test_read_at();
    send_byte(8'h00, 0);
    send_byte(8'hE8, 0);
    send_byte(8'h10, 0);
    checks++; if (bus_if.bus_addr_o !== 17'h0E810 || bus_if.bus_we_o !== 1'b0 || bus_if.bus_req_o !== 1'b1) begin
      failures++; $display("FAIL rd_at_access addr=%h we=%b req=%b exp 0e810/0/1", bus_if.bus_addr_o, bus_if.bus_we_o, bus_if.bus_req_o);
    end
    tick();
    grant(8'h3C);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus_if.rd_valid_o !== 1'b1 || bus_if.rd_data_o !== 8'h3C || bus_if.cmd_ready_o !== 1'b0 || bus_if.bus_req_o !== 1'b0) begin
        failures++;
        $display("FAIL rd_at_result valid=%b data=%h ready=%b req=%b exp 1/3c/0/0",
                 bus_if.rd_valid_o, bus_if.rd_data_o, bus_if.cmd_ready_o, bus_if.bus_req_o);
      end
      tick();
    end
    bus_if.rd_ready_i = 1'b1;
    tick();
    bus_if.rd_ready_i = 1'b0;
    checks++; if (bus_if.rd_valid_o !== 1'b0) begin failures++; $display("FAIL rd_at_consumed got=%b exp=0", bus_if.rd_valid_o); end
    checks++; if (bus_if.rd_data_o !== 8'h3C) begin failures++; $display("FAIL rd_at_data_hold got=%h exp=3c", bus_if.rd_data_o); end
    checks++; if (bus_if.cmd_ready_o !== 1'b1) begin failures++; $display("FAIL rd_at_idle_ready got=%b exp=1", bus_if.cmd_ready_o); end
  endtask

  task automatic test_grant_ignored();
    grant(8'hAA);
    checks++; if (bus_if.cmd_ready_o !== 1'b1 || bus_if.rd_valid_o !== 1'b0 || bus_if.rd_data_o !== 8'h3C || bus_if.bus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_grant ready=%b valid=%b data=%h req=%b exp 1/0/3c/0",
               bus_if.cmd_ready_o, bus_if.rd_valid_o, bus_if.rd_data_o, bus_if.bus_req_o);
    end
  endtask

  task automatic test_wrap();
    send_byte(8'h01, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    checks++; if (bus_if.bus_addr_o !== 17'h1FFFF) begin failures++; $display("FAIL wrap_first_addr got=%h exp=1ffff", bus_if.bus_addr_o); end
    grant(8'h11);
    bus_if.rd_ready_i = 1'b1;
    tick();
    bus_if.rd_ready_i = 1'b0;
    send_byte(8'h40, 0);
    checks++; if (bus_if.bus_req_o !== 1'b1) begin failures++; $display("FAIL wrap_next_req got=%b exp=1", bus_if.bus_req_o); end
    checks++; if (bus_if.bus_addr_o !== 17'h00000) begin failures++; $display("FAIL wrap_next_addr got=%h exp=00000", bus_if.bus_addr_o); end
    // grant and rd_ready together must still show RESULT for one cycle
    bus_if.rd_ready_i = 1'b1;
    grant(8'h22);
    checks++; if (bus_if.rd_valid_o !== 1'b1 || bus_if.rd_data_o !== 8'h22) begin
      failures++; $display("FAIL same_cycle_result valid=%b data=%h exp 1/22", bus_if.rd_valid_o, bus_if.rd_data_o);
    end
    tick();
    bus_if.rd_ready_i = 1'b0;
    checks++; if (bus_if.rd_valid_o !== 1'b0) begin failures++; $display("FAIL same_cycle_release got=%b exp=0", bus_if.rd_valid_o); end
  endtask

  task automatic test_unknown();
    send_byte(8'hA0, 0);
    checks++; if (bus_if.err_o !== 1'b1) begin failures++; $display("FAIL unknown_err got=%b exp=1", bus_if.err_o); end
    checks++; if (bus_if.bus_req_o !== 1'b0 || bus_if.cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL unknown_idle req=%b ready=%b exp 0/1", bus_if.bus_req_o, bus_if.cmd_ready_o);
    end
    send_byte(8'h60, 0);
    send_byte(8'h77, 0);
    checks++; if (bus_if.bus_req_o !== 1'b1 || bus_if.bus_addr_o !== 17'h00001 || bus_if.bus_we_o !== 1'b1 || bus_if.bus_wr_data_o !== 8'h77) begin
      failures++;
      $display("FAIL wr_next_access req=%b addr=%h we=%b data=%h exp 1/00001/1/77",
               bus_if.bus_req_o, bus_if.bus_addr_o, bus_if.bus_we_o, bus_if.bus_wr_data_o);
    end
    grant(8'h00);
    checks++; if (bus_if.err_o !== 1'b1 || bus_if.cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL err_sticky err=%b ready=%b exp 1/1", bus_if.err_o, bus_if.cmd_ready_o);
    end
  endtask

  task automatic test_reset_access();
    send_byte(8'h40, 0);
    checks++; if (bus_if.bus_req_o !== 1'b1 || bus_if.bus_addr_o !== 17'h00002) begin
      failures++; $display("FAIL rst_acc_pre req=%b addr=%h exp 1/00002", bus_if.bus_req_o, bus_if.bus_addr_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus_if.bus_req_o !== 1'b0) begin failures++; $display("FAIL rst_acc_req got=%b exp=0", bus_if.bus_req_o); end
    grant(8'h55);
    checks++; if (bus_if.rd_valid_o !== 1'b0 || bus_if.bus_req_o !== 1'b0 || bus_if.cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_acc_grant valid=%b req=%b ready=%b exp 0/0/1", bus_if.rd_valid_o, bus_if.bus_req_o, bus_if.cmd_ready_o);
    end
    checks++; if (bus_if.rd_data_o !== 8'h00 || bus_if.err_o !== 1'b0 || bus_if.bus_addr_o !== 17'h00000) begin
      failures++; $display("FAIL rst_acc_regs data=%h err=%b addr=%h exp 00/0/00000", bus_if.rd_data_o, bus_if.err_o, bus_if.bus_addr_o);
    end
  endtask

  task automatic test_random();
    logic [16:0] m_addr;
    logic [16:0] exp_addr;
    logic [16:0] a;
    logic [7:0]  d;
    logic [7:0]  rdv;
    logic [3:0]  junk;
    logic        exp_we;
    int          kind;
    do_reset();
    m_addr = 17'h00000;
    for (int i = 0; i < 1000; i++) begin
      kind = $urandom_range(0, 4);
      a    = 17'($urandom);
      d    = 8'($urandom);
      rdv  = 8'($urandom);
      junk = 4'($urandom_range(0, 15));
      exp_addr = a;
      exp_we   = 1'b0;
      case (kind)
        0: begin
          send_byte({3'b000, junk, a[16]}, $urandom_range(0, 2));
          send_byte(a[15:8], $urandom_range(0, 2));
          send_byte(a[7:0], $urandom_range(0, 2));
        end
        1: begin
          exp_we = 1'b1;
          send_byte({3'b001, junk, a[16]}, $urandom_range(0, 2));
          send_byte(d, $urandom_range(0, 2));
          send_byte(a[15:8], $urandom_range(0, 2));
          send_byte(a[7:0], $urandom_range(0, 2));
        end
        2: begin
          exp_addr = m_addr + 17'd1;
          send_byte({3'b010, junk, a[16]}, $urandom_range(0, 2));
        end
        3: begin
          exp_addr = m_addr + 17'd1;
          exp_we   = 1'b1;
          send_byte({3'b011, junk, a[16]}, $urandom_range(0, 2));
          send_byte(d, $urandom_range(0, 2));
        end
        default: send_byte({1'b1, d[1:0], junk, a[16]}, $urandom_range(0, 2));
      endcase
      if (kind == 4) begin
        checks++; if (bus_if.err_o !== 1'b1 || bus_if.bus_req_o !== 1'b0) begin
          failures++; $display("FAIL rnd_unknown i=%0d err=%b req=%b exp 1/0", i, bus_if.err_o, bus_if.bus_req_o);
        end
      end else begin
        m_addr = exp_addr;
        checks++;
        if (bus_if.bus_req_o !== 1'b1 || bus_if.bus_addr_o !== exp_addr || bus_if.bus_we_o !== exp_we ||
            (exp_we && bus_if.bus_wr_data_o !== d)) begin
          failures++;
          $display("FAIL rnd_access i=%0d req=%b addr=%h we=%b data=%h exp 1/%h/%b/%h",
                   i, bus_if.bus_req_o, bus_if.bus_addr_o, bus_if.bus_we_o, bus_if.bus_wr_data_o, exp_addr, exp_we, d);
        end
        repeat ($urandom_range(0, 3)) tick();
        checks++; if (bus_if.bus_req_o !== 1'b1 || bus_if.bus_addr_o !== exp_addr) begin
          failures++; $display("FAIL rnd_hold i=%0d req=%b addr=%h exp 1/%h", i, bus_if.bus_req_o, bus_if.bus_addr_o, exp_addr);
        end
        grant(rdv);
        if (exp_we) begin
          checks++; if (bus_if.cmd_ready_o !== 1'b1 || bus_if.rd_valid_o !== 1'b0) begin
            failures++; $display("FAIL rnd_wr_done i=%0d ready=%b valid=%b exp 1/0", i, bus_if.cmd_ready_o, bus_if.rd_valid_o);
          end
        end else begin
          checks++; if (bus_if.rd_valid_o !== 1'b1 || bus_if.rd_data_o !== rdv) begin
            failures++; $display("FAIL rnd_rd_result i=%0d valid=%b data=%h exp 1/%h", i, bus_if.rd_valid_o, bus_if.rd_data_o, rdv);
          end
          repeat ($urandom_range(0, 3)) tick();
          bus_if.rd_ready_i = 1'b1;
          tick();
          bus_if.rd_ready_i = 1'b0;
          checks++; if (bus_if.rd_valid_o !== 1'b0) begin
            failures++; $display("FAIL rnd_rd_release i=%0d valid=%b exp 0", i, bus_if.rd_valid_o);
          end
        end
      end
    end
  endtask

  initial begin
    bus_if.cmd_data_i    = 8'h00;
    bus_if.cmd_valid_i   = 1'b0;
    bus_if.bus_grant_i   = 1'b0;
    bus_if.bus_rd_data_i = 8'h00;
    bus_if.rd_ready_i    = 1'b0;
    test_reset();
    test_write_at();
    test_read_at();
    test_grant_ignored();
    test_wrap();
    test_unknown();
    test_reset_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
